// File: rtl/mic_pkg.sv
// Shared definitions for the PmodMIC capture path: FSM encoding, frame/sample widths
// and the frame-to-sample conversion.
package mic_pkg;

    localparam int SAMPLE_W = 12;
    localparam int FRAME_W  = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_TICK = 3'd1;
    localparam logic [2:0] ST_CONVERT   = 3'd2;
    localparam logic [2:0] ST_STORE     = 3'd3;
    localparam logic [2:0] ST_FINISH    = 3'd4;

    // The frame carries 4 leading zeros; only the 12-bit code is kept.
    function automatic logic [SAMPLE_W-1:0] frame_to_sample(
        input logic [FRAME_W-1:0] frame,
        input bit                 signed_out
    );
        logic [SAMPLE_W-1:0] s;
        s = frame[SAMPLE_W-1:0];
        if (signed_out) s[SAMPLE_W-1] = ~s[SAMPLE_W-1];
        return s;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate pacer: 1-cycle tick every SAMPLE_DIV cycles, first tick SAMPLE_DIV-1 cycles after clr drops.
// No backpressure; clr holds the counter at zero and suppresses the tick.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 200
) (
    input  logic clk_sclk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sclk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/mic_capture_ctrl.sv
// Record sequencer: paces PmodMIC conversions, writes 12-bit samples to the record buffer.
// Latency: mic_done -> wr_en 1 cycle; last write -> rec_done 1 cycle. No backpressure: late mic_done flags overrun.
module mic_capture_ctrl
    import mic_pkg::*;
#(
    parameter int SAMPLE_DIV = 200,
    parameter int AW         = 14,
    parameter int TIMEOUT    = 32,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  logic                clk_sclk,
    input  logic                rst,
    input  logic                rec_req,
    input  logic [AW:0]         rec_len,
    input  logic                abort,
    output logic                busy,
    output logic                rec_done,
    output logic                overrun,
    output logic                timeout_err,
    output logic                mic_en,
    output logic                mic_start,
    input  logic                mic_done,
    input  logic [FRAME_W-1:0]  mic_pdata,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [SAMPLE_W-1:0] wr_data
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [2:0]          state, state_nxt;
    logic [AW:0]         len_q;
    logic [AW:0]         cnt_q;
    logic [TW-1:0]       to_cnt;
    logic [SAMPLE_W-1:0] sample_q;
    logic                tick;
    logic                accept;
    logic                last_sample;
    logic                to_expire;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk_sclk (clk_sclk),
        .rst      (rst),
        .clr      (state == ST_IDLE),
        .tick     (tick)
    );

    assign accept      = (state == ST_IDLE) && rec_req && !abort;
    assign last_sample = ((cnt_q + CNT_ONE) == len_q);
    // to_cnt holds the number of cycles elapsed since mic_start
    assign to_expire   = (to_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_WAIT_TICK;
            end
            ST_WAIT_TICK: begin
                if (len_q == '0)  state_nxt = ST_FINISH;
                else if (tick)    state_nxt = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (mic_done)       state_nxt = ST_STORE;
                else if (to_expire) state_nxt = ST_IDLE;
            end
            ST_STORE: begin
                state_nxt = last_sample ? ST_FINISH : ST_WAIT_TICK;
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_sclk) begin
        if (rst) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            to_cnt      <= '0;
            sample_q    <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        len_q       <= rec_len;
                        cnt_q       <= '0;
                        overrun     <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                ST_WAIT_TICK: begin
                    if (tick) to_cnt <= TW'(1);
                end
                ST_CONVERT: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (tick && !abort) overrun <= 1'b1;
                    if (mic_done) begin
                        sample_q <= frame_to_sample(mic_pdata, SIGNED_OUT);
                    end else if (to_expire && !abort) begin
                        timeout_err <= 1'b1;
                    end
                end
                ST_STORE: begin
                    if (!abort) cnt_q <= cnt_q + CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign mic_en    = busy;
    assign rec_done  = (state == ST_FINISH);
    assign mic_start = (state == ST_WAIT_TICK) && (len_q != '0) && tick && !abort;
    assign wr_en     = (state == ST_STORE) && !abort;
    assign wr_addr   = cnt_q[AW-1:0];
    assign wr_data   = sample_q;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl with a behavioural PmodMIC responder and event logs.
module tb_mic_capture_ctrl;

    localparam int SAMPLE_DIV = 24;
    localparam int AW         = 3;
    localparam int TIMEOUT    = 32;

    logic          clk_sclk = 1'b0;
    logic          rst;
    logic          rec_req;
    logic [AW:0]   rec_len;
    logic          abort;
    logic          busy, rec_done, overrun, timeout_err, mic_en, mic_start;
    logic          mic_done;
    logic [15:0]   mic_pdata;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;

    typedef struct { int c; int addr; int data; } wr_ev_t;
    typedef struct { logic [15:0] frame; int exp_addr; int exp_data; int exp_cyc; } vec_t;

    wr_ev_t      wr_log[$];
    int          start_log[$];
    int          done_log[$];
    logic [15:0] frames[$];
    int          busy_cnt = 0;
    int          cyc      = 0;
    int          due      = -1;
    int          delay    = 18;
    bit          withhold = 1'b0;
    int          n_chk    = 0;
    int          n_pass   = 0;

    mic_capture_ctrl #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .AW         (AW),
        .TIMEOUT    (TIMEOUT),
        .SIGNED_OUT (1'b1)
    ) dut (
        .clk_sclk    (clk_sclk),
        .rst         (rst),
        .rec_req     (rec_req),
        .rec_len     (rec_len),
        .abort       (abort),
        .busy        (busy),
        .rec_done    (rec_done),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .mic_en      (mic_en),
        .mic_start   (mic_start),
        .mic_done    (mic_done),
        .mic_pdata   (mic_pdata),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    always #5 clk_sclk = ~clk_sclk;

    always @(posedge clk_sclk) cyc <= cyc + 1;

    always @(negedge clk_sclk) begin
        wr_ev_t ev;
        if (wr_en) begin
            ev.c = cyc; ev.addr = int'(wr_addr); ev.data = int'(wr_data);
            wr_log.push_back(ev);
        end
        if (mic_start) begin
            start_log.push_back(cyc);
            due = cyc + delay;
        end
        if (rec_done) done_log.push_back(cyc);
        if (busy) busy_cnt++;
    end

    // PmodMIC stand-in: one-cycle mic_done 'delay' cycles after each start
    initial begin
        mic_done  = 1'b0;
        mic_pdata = 16'h0000;
        forever begin
            @(posedge clk_sclk); #1;
            mic_done = !withhold && (cyc == due);
            if (mic_done && frames.size() > 0) mic_pdata = frames.pop_front();
            else                               mic_pdata = 16'hA5A5;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic wr_ev_t wr_at(input int i);
        wr_ev_t e;
        e.c = -1; e.addr = -1; e.data = -1;
        if (i < wr_log.size()) e = wr_log[i];
        return e;
    endfunction

    function automatic int start_at(input int i);
        return (i < start_log.size()) ? start_log[i] : -1;
    endfunction

    function automatic int done_at(input int i);
        return (i < done_log.size()) ? done_log[i] : -1;
    endfunction

    task automatic clear_logs();
        wr_log.delete(); start_log.delete(); done_log.delete(); frames.delete();
        busy_cnt = 0;
    endtask

    task automatic to_cycle(input int n);
        do @(negedge clk_sclk); while (cyc < n);
    endtask

    task automatic start_rec(input int len, output int acc);
        @(posedge clk_sclk); #1;
        rec_req = 1'b1;
        rec_len = len[AW:0];
        acc     = cyc;
        @(posedge clk_sclk); #1;
        rec_req = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"},        busy,        1'b0);
        chk({tag, " rec_done"},    rec_done,    1'b0);
        chk({tag, " mic_en"},      mic_en,      1'b0);
        chk({tag, " mic_start"},   mic_start,   1'b0);
        chk({tag, " wr_en"},       wr_en,       1'b0);
        chk({tag, " wr_addr"},     wr_addr,     '0);
        chk({tag, " wr_data"},     wr_data,     '0);
        chk({tag, " overrun"},     overrun,     1'b0);
        chk({tag, " timeout_err"}, timeout_err, 1'b0);
    endtask

    initial begin
        vec_t   vt[4];
        vec_t   vo[3];
        wr_ev_t e;
        int     a;
        int     s;

        // rec_len=4, delay 18: writes at acceptance+43 then every SAMPLE_DIV
        vt[0] = '{16'h0800, 0, 'h000, 43};
        vt[1] = '{16'h0FFF, 1, 'h7FF, 67};
        vt[2] = '{16'h0000, 2, 'h800, 91};
        vt[3] = '{16'h0123, 3, 'h923, 115};
        // rec_len=3, delay 30: one slot skipped per sample, upper frame bits ignored
        vo[0] = '{16'h0123, 0, 'h923, 55};
        vo[1] = '{16'hF001, 1, 'h801, 103};
        vo[2] = '{16'h0FFF, 2, 'h7FF, 151};

        rst = 1'b1; rec_req = 1'b0; abort = 1'b0; rec_len = '0;
        repeat (3) @(posedge clk_sclk);
        @(negedge clk_sclk);
        chk_idle("reset");
        @(posedge clk_sclk); #1;
        rst = 1'b0;

        // normal record of 4 samples, plus a rec_req while busy that must be ignored
        clear_logs(); delay = 18;
        foreach (vt[i]) frames.push_back(vt[i].frame);
        start_rec(4, a);
        @(negedge clk_sclk);
        chk("t2 busy after accept", busy, 1'b1);
        chk("t2 mic_en after accept", mic_en, 1'b1);
        to_cycle(a + 60);
        @(posedge clk_sclk); #1; rec_req = 1'b1; rec_len = 4'd1;
        @(posedge clk_sclk); #1; rec_req = 1'b0;
        to_cycle(a + 130);
        for (int i = 0; i < 4; i++) begin
            e = wr_at(i);
            chk($sformatf("t2 addr[%0d]", i), e.addr, vt[i].exp_addr);
            chk($sformatf("t2 data[%0d]", i), e.data, vt[i].exp_data);
            chk($sformatf("t2 wr cyc[%0d]", i), e.c, a + vt[i].exp_cyc);
            chk($sformatf("t2 start cyc[%0d]", i), start_at(i), a + SAMPLE_DIV * (i + 1));
        end
        chk("t2 writes", wr_log.size(), 4);
        chk("t2 done count", done_log.size(), 1);
        chk("t2 done cyc", done_at(0), a + 116);
        chk("t2 busy end", busy, 1'b0);
        chk("t2 overrun", overrun, 1'b0);

        // zero-length record
        clear_logs();
        start_rec(0, a);
        to_cycle(a + 40);
        chk("t3 busy cycles", busy_cnt, 2);
        chk("t3 done cyc", done_at(0), a + 2);
        chk("t3 done count", done_log.size(), 1);
        chk("t3 writes", wr_log.size(), 0);
        chk("t3 starts", start_log.size(), 0);

        // missing mic_done
        clear_logs(); withhold = 1'b1;
        start_rec(2, a);
        s = a + SAMPLE_DIV;
        to_cycle(s + TIMEOUT - 1);
        chk("t4 timeout_err early", timeout_err, 1'b0);
        chk("t4 busy early", busy, 1'b1);
        to_cycle(s + TIMEOUT);
        chk("t4 timeout_err", timeout_err, 1'b1);
        chk("t4 busy", busy, 1'b0);
        to_cycle(s + TIMEOUT + 40);
        chk("t4 start cyc", start_at(0), s);
        chk("t4 starts", start_log.size(), 1);
        chk("t4 done count", done_log.size(), 0);
        chk("t4 writes", wr_log.size(), 0);
        chk("t4 timeout_err sticky", timeout_err, 1'b1);
        withhold = 1'b0;

        // conversion slower than the sample period
        clear_logs(); delay = 30;
        foreach (vo[i]) frames.push_back(vo[i].frame);
        start_rec(3, a);
        chk("t5 timeout_err cleared", timeout_err, 1'b0);
        to_cycle(a + 48);
        chk("t5 overrun before tick", overrun, 1'b0);
        to_cycle(a + 49);
        chk("t5 overrun after tick", overrun, 1'b1);
        to_cycle(a + 170);
        for (int i = 0; i < 3; i++) begin
            e = wr_at(i);
            chk($sformatf("t5 addr[%0d]", i), e.addr, vo[i].exp_addr);
            chk($sformatf("t5 data[%0d]", i), e.data, vo[i].exp_data);
            chk($sformatf("t5 wr cyc[%0d]", i), e.c, a + vo[i].exp_cyc);
            chk($sformatf("t5 start cyc[%0d]", i), start_at(i), a + 24 + 48 * i);
        end
        chk("t5 starts", start_log.size(), 3);
        chk("t5 done cyc", done_at(0), a + 152);
        chk("t5 timeout_err", timeout_err, 1'b0);

        // abort on the STORE cycle of sample 2, then rec_req+abort together
        clear_logs(); delay = 18;
        for (int i = 0; i < 5; i++) frames.push_back(16'h0100 + 16'(i));
        start_rec(5, a);
        chk("t6 overrun cleared", overrun, 1'b0);
        to_cycle(a + 90);
        @(posedge clk_sclk); #1; abort = 1'b1;
        @(negedge clk_sclk);
        chk("t6 wr_en suppressed", wr_en, 1'b0);
        chk("t6 busy during abort", busy, 1'b1);
        @(posedge clk_sclk); #1; abort = 1'b0;
        @(negedge clk_sclk);
        chk("t6 busy after abort", busy, 1'b0);
        @(posedge clk_sclk); #1; rec_req = 1'b1; abort = 1'b1; rec_len = 4'd2;
        @(posedge clk_sclk); #1; rec_req = 1'b0; abort = 1'b0;
        @(negedge clk_sclk);
        chk("t6 req+abort stays idle", busy, 1'b0);
        to_cycle(a + 160);
        chk("t6 writes", wr_log.size(), 2);
        chk("t6 last addr", wr_at(1).addr, 1);
        chk("t6 starts", start_log.size(), 3);
        chk("t6 done count", done_log.size(), 0);

        // reset during sample 3 of 8
        clear_logs(); delay = 18;
        for (int i = 0; i < 8; i++) frames.push_back(16'h0200 + 16'(i));
        start_rec(8, a);
        to_cycle(a + 99);
        @(posedge clk_sclk); #1; rst = 1'b1;
        @(posedge clk_sclk); #1; rst = 1'b0;
        @(negedge clk_sclk);
        chk_idle("t1");
        to_cycle(a + 200);
        chk("t1 writes", wr_log.size(), 3);
        chk("t1 starts", start_log.size(), 4);
        chk("t1 done count", done_log.size(), 0);

        // full-length record: addresses 0..2**AW-1 without wrap
        clear_logs(); delay = 5;
        for (int i = 0; i < 8; i++) frames.push_back(16'(i) * 16'h0111);
        start_rec(8, a);
        to_cycle(a + 240);
        for (int i = 0; i < 8; i++) chk($sformatf("t7 addr[%0d]", i), wr_at(i).addr, i);
        chk("t7 last data", wr_at(7).data, 'hF77);
        chk("t7 writes", wr_log.size(), 8);
        chk("t7 done cyc", done_at(0), a + 199);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
